// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prog_sequencer
//  Purpose  : Program sequencer for the single-cycle core. Owns the program
//             counter and a run-control FSM implementing a 4-phase req/done
//             handshake. It generates a one-cycle core clear pulse, supports
//             stalls, counts RUN cycles (saturating) and provides an optional
//             watchdog that ends a run after MAX_CYCLES RUN cycles.
//
//  Ports    : clk         - clock, all state updates on rising edge
//             reset       - synchronous active-high reset
//             req         - run request (held high until done)
//             halt        - program finished at current prog_ctr
//             branch      - taken branch (ALU flag OR control flag)
//             target      - branch target from the PC LUT
//             stall       - hold the PC this cycle
//             prog_ctr    - current program counter (registered)
//             core_en     - high in RUN (combinational from state)
//             core_rst    - core clear: reset or CLEAR state (combinational)
//             busy        - high in CLEAR and RUN (combinational)
//             done        - run finished (registered)
//             timeout     - run ended by watchdog, valid while done = 1
//             cycle_count - RUN cycles of current/last run, saturating
//
//  Revision : 1.0  initial release
// ============================================================================
module prog_sequencer #(
    parameter int PC_W       = 12,
    parameter int START_ADDR = 0,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt,
    input  logic             branch,
    input  logic [PC_W-1:0]  target,
    input  logic             stall,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             core_en,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CYC_W-1:0] cycle_count
);

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_SAT  = '1;

    // The RUN-cycle index (cycle_count + 1) can reach 2^CYC_W, so a limit is
    // only reachable if it fits in CYC_W+1 bits. Larger limits would alias
    // after truncation, so they disable the watchdog instead.
    localparam bit WDOG_EN = (MAX_CYCLES > 0) &&
                             ($clog2(MAX_CYCLES + 1) <= CYC_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;

    logic             w_wdog_hit;

    // ------------------------------------------------------------------
    // Watchdog: fires when the current RUN cycle is cycle number MAX_CYCLES.
    // cnt_q holds the number of RUN cycles already retired, so the current
    // cycle's 1-based index is cnt_q + 1.
    // ------------------------------------------------------------------
    generate
        if (WDOG_EN) begin : g_wdog
            localparam logic [CYC_W:0] WDOG_LIMIT = (CYC_W + 1)'(MAX_CYCLES);
            logic [CYC_W:0] w_run_idx;
            assign w_run_idx  = {1'b0, cnt_q} + {{CYC_W{1'b0}}, 1'b1};
            assign w_wdog_hit = (w_run_idx == WDOG_LIMIT);
        end else begin : g_no_wdog
            assign w_wdog_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                pc_d      = START_PC;
                cnt_d     = '0;
                done_d    = 1'b0;
                timeout_d = 1'b0;
                state_d   = ST_RUN;
            end

            ST_RUN: begin
                if (!req) begin
                    // Abort: PC and counter freeze, done never rises.
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != CYC_SAT) begin
                        cnt_d = cnt_q + CYC_ONE;
                    end
                    // A stall masks halt, watchdog and branch for this cycle.
                    if (!stall) begin
                        if (halt) begin
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                            timeout_d = 1'b0;
                        end else if (w_wdog_hit) begin
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                            timeout_d = 1'b1;
                        end else if (branch) begin
                            pc_d = target;
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                // timeout and cycle_count are kept for readout after the run.
                if (!req) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign prog_ctr    = pc_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;

    // Decoded from the state register; reset forces the core quiet and clear
    // even before the first edge has moved the FSM back to IDLE.
    assign core_en  = (state_q == ST_RUN) && !reset;
    assign busy     = ((state_q == ST_CLEAR) || (state_q == ST_RUN)) && !reset;
    assign core_rst = reset || (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_sequencer
//  Purpose  : Self-checking bench for prog_sequencer. Three instances cover
//             the default build, a watchdog build (MAX_CYCLES = 10) and a
//             narrow-PC build (PC_W = 4, START_ADDR = 14).
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req_wd, req_wr;
    logic        halt, branch, stall;
    logic [11:0] target;

    logic [11:0] pc, pc_wd;
    logic [3:0]  pc_wr;
    logic        core_en, core_rst, busy, done, timeout;
    logic        core_en_wd, core_rst_wd, busy_wd, done_wd, timeout_wd;
    logic        core_en_wr, core_rst_wr, busy_wr, done_wr, timeout_wr;
    logic [15:0] cnt, cnt_wd, cnt_wr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] exp_pc_q[$];

    always #5 clk = ~clk;

    prog_sequencer #(.PC_W(12), .START_ADDR(0), .CYC_W(16), .MAX_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .req(req), .halt(halt), .branch(branch),
        .target(target), .stall(stall), .prog_ctr(pc), .core_en(core_en),
        .core_rst(core_rst), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cnt)
    );

    prog_sequencer #(.PC_W(12), .START_ADDR(0), .CYC_W(16), .MAX_CYCLES(10)) dut_wd (
        .clk(clk), .reset(reset), .req(req_wd), .halt(halt), .branch(branch),
        .target(target), .stall(stall), .prog_ctr(pc_wd), .core_en(core_en_wd),
        .core_rst(core_rst_wd), .busy(busy_wd), .done(done_wd), .timeout(timeout_wd),
        .cycle_count(cnt_wd)
    );

    prog_sequencer #(.PC_W(4), .START_ADDR(14), .CYC_W(16), .MAX_CYCLES(0)) dut_wr (
        .clk(clk), .reset(reset), .req(req_wr), .halt(halt), .branch(branch),
        .target(target[3:0]), .stall(stall), .prog_ctr(pc_wr), .core_en(core_en_wr),
        .core_rst(core_rst_wr), .busy(busy_wr), .done(done_wr), .timeout(timeout_wr),
        .cycle_count(cnt_wr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (pc !== 12'd0) begin n_bad++; $display("FAIL reset_pc got %0d want 0", pc); end
        n_cmp++; if ({done, timeout, busy, core_en} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags got done/to/busy/en=%b want 0000", {done, timeout, busy, core_en}); end
        n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        n_cmp++; if (core_rst !== 1'b1) begin n_bad++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        n_cmp++; if (core_rst_wr !== 1'b1 || pc_wr !== 4'd14) begin n_bad++;
            $display("FAIL reset_wrap got rst=%b pc=%0d want rst=1 pc=14", core_rst_wr, pc_wr); end
        reset = 1'b0;
        tick();
        n_cmp++; if (core_rst !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_after_reset got rst=%b busy=%b want 0 0", core_rst, busy); end
    endtask

    task automatic test_straight_line();
        logic [11:0] e;
        req = 1'b1;
        tick();
        n_cmp++; if ({busy, core_rst, core_en} !== 3'b110) begin n_bad++;
            $display("FAIL clear_state got busy/rst/en=%b want 110", {busy, core_rst, core_en}); end
        tick();
        for (int i = 0; i < 6; i++) exp_pc_q.push_back(12'(i));
        for (int i = 0; i < 6; i++) begin
            e = exp_pc_q.pop_front();
            n_cmp++; if (pc !== e || cnt !== 16'(i) || core_en !== 1'b1 || done !== 1'b0) begin n_bad++;
                $display("FAIL straight_run[%0d] got pc=%0d cnt=%0d en=%b done=%b want pc=%0d cnt=%0d en=1 done=0",
                         i, pc, cnt, core_en, done, e, i); end
            halt = (i == 5);
            tick();
        end
        halt = 1'b0;
        n_cmp++; if (done !== 1'b1 || timeout !== 1'b0 || cnt !== 16'd6 || pc !== 12'd5 || core_en !== 1'b0) begin n_bad++;
            $display("FAIL straight_done got done=%b to=%b cnt=%0d pc=%0d en=%b want 1 0 6 5 0",
                     done, timeout, cnt, pc, core_en); end
        tick();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++;
            $display("FAIL done_hold got done=%b busy=%b want 1 0", done, busy); end
        req = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b0 || cnt !== 16'd6) begin n_bad++;
            $display("FAIL done_release got done=%b cnt=%0d want 0 6", done, cnt); end
    endtask

    task automatic test_branch_halt();
        logic [11:0] e;
        req = 1'b1;
        target = 12'h020;
        tick(); tick();
        exp_pc_q.push_back(12'h000); exp_pc_q.push_back(12'h001);
        exp_pc_q.push_back(12'h002); exp_pc_q.push_back(12'h020);
        for (int i = 0; i < 4; i++) begin
            e = exp_pc_q.pop_front();
            n_cmp++; if (pc !== e || done !== 1'b0) begin n_bad++;
                $display("FAIL branch_run[%0d] got pc=%h done=%b want pc=%h done=0", i, pc, done, e); end
            branch = (i >= 2);
            halt   = (i == 3);
            tick();
        end
        branch = 1'b0; halt = 1'b0;
        n_cmp++; if (done !== 1'b1 || pc !== 12'h020 || cnt !== 16'd4 || timeout !== 1'b0) begin n_bad++;
            $display("FAIL branch_halt got done=%b pc=%h cnt=%0d to=%b want 1 020 4 0", done, pc, cnt, timeout); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [11:0] e;
        req = 1'b1;
        tick(); tick();
        exp_pc_q.push_back(12'd0); exp_pc_q.push_back(12'd1); exp_pc_q.push_back(12'd2);
        exp_pc_q.push_back(12'd3); exp_pc_q.push_back(12'd3); exp_pc_q.push_back(12'd3);
        exp_pc_q.push_back(12'd3); exp_pc_q.push_back(12'd4);
        for (int i = 0; i < 8; i++) begin
            e = exp_pc_q.pop_front();
            n_cmp++; if (pc !== e || cnt !== 16'(i) || done !== 1'b0) begin n_bad++;
                $display("FAIL stall_run[%0d] got pc=%0d cnt=%0d done=%b want pc=%0d cnt=%0d done=0",
                         i, pc, cnt, done, e, i); end
            stall = (i >= 3 && i <= 5);
            halt  = (i >= 3 && i <= 5) || (i == 7);
            tick();
        end
        stall = 1'b0; halt = 1'b0;
        n_cmp++; if (done !== 1'b1 || pc !== 12'd4 || cnt !== 16'd8) begin n_bad++;
            $display("FAIL stall_done got done=%b pc=%0d cnt=%0d want 1 4 8", done, pc, cnt); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        logic [11:0] e;
        req_wd = 1'b1;
        tick(); tick();
        for (int i = 0; i < 10; i++) exp_pc_q.push_back(12'(i));
        for (int i = 0; i < 10; i++) begin
            e = exp_pc_q.pop_front();
            n_cmp++; if (pc_wd !== e || done_wd !== 1'b0 || core_en_wd !== 1'b1 || timeout_wd !== 1'b0) begin n_bad++;
                $display("FAIL wdog_run[%0d] got pc=%0d done=%b en=%b to=%b want pc=%0d done=0 en=1 to=0",
                         i, pc_wd, done_wd, core_en_wd, timeout_wd, e); end
            tick();
        end
        n_cmp++; if (done_wd !== 1'b1 || timeout_wd !== 1'b1 || cnt_wd !== 16'd10 || pc_wd !== 12'd9) begin n_bad++;
            $display("FAIL wdog_fire got done=%b to=%b cnt=%0d pc=%0d want 1 1 10 9", done_wd, timeout_wd, cnt_wd, pc_wd); end
        req_wd = 1'b0;
        tick();
        n_cmp++; if (done_wd !== 1'b0 || timeout_wd !== 1'b1 || cnt_wd !== 16'd10) begin n_bad++;
            $display("FAIL wdog_readout got done=%b to=%b cnt=%0d want 0 1 10", done_wd, timeout_wd, cnt_wd); end
        req_wd = 1'b1;
        tick(); tick();
        n_cmp++; if (timeout_wd !== 1'b0 || cnt_wd !== 16'd0 || pc_wd !== 12'd0) begin n_bad++;
            $display("FAIL wdog_restart got to=%b cnt=%0d pc=%0d want 0 0 0", timeout_wd, cnt_wd, pc_wd); end
        req_wd = 1'b0;
        tick();
    endtask

    task automatic test_no_watchdog_abort();
        logic seen_done = 1'b0;
        req = 1'b1;
        tick(); tick();
        for (int i = 0; i < 1000; i++) begin
            seen_done = seen_done | done;
            tick();
        end
        n_cmp++; if (seen_done !== 1'b0 || done !== 1'b0) begin n_bad++;
            $display("FAIL no_wdog got seen_done=%b done=%b want 0 0", seen_done, done); end
        n_cmp++; if (cnt !== 16'd1000 || pc !== 12'd1000) begin n_bad++;
            $display("FAIL long_run got cnt=%0d pc=%0d want 1000 1000", cnt, pc); end
        req = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pc !== 12'd1000 || cnt !== 16'd1000) begin n_bad++;
            $display("FAIL abort_main got busy=%b done=%b pc=%0d cnt=%0d want 0 0 1000 1000", busy, done, pc, cnt); end
    endtask

    task automatic test_wrap_abort();
        logic [11:0] e;
        req_wr = 1'b1;
        tick(); tick();
        exp_pc_q.push_back(12'd14); exp_pc_q.push_back(12'd15);
        exp_pc_q.push_back(12'd0);  exp_pc_q.push_back(12'd1);
        for (int i = 0; i < 4; i++) begin
            e = exp_pc_q.pop_front();
            n_cmp++; if ({8'h00, pc_wr} !== e) begin n_bad++;
                $display("FAIL wrap_run[%0d] got pc=%0d want %0d", i, pc_wr, e); end
            tick();
        end
        req_wr = 1'b0;
        tick();
        n_cmp++; if (busy_wr !== 1'b0 || core_en_wr !== 1'b0 || done_wr !== 1'b0 || pc_wr !== 4'd2 || cnt_wr !== 16'd4) begin n_bad++;
            $display("FAIL wrap_abort got busy=%b en=%b done=%b pc=%0d cnt=%0d want 0 0 0 2 4",
                     busy_wr, core_en_wr, done_wr, pc_wr, cnt_wr); end
        tick();
        n_cmp++; if (done_wr !== 1'b0 || busy_wr !== 1'b0) begin n_bad++;
            $display("FAIL wrap_idle got done=%b busy=%b want 0 0", done_wr, busy_wr); end
    endtask

    task automatic test_reset_midrun();
        logic [11:0] e;
        req = 1'b1;
        tick(); tick();
        for (int i = 0; i < 8; i++) exp_pc_q.push_back(12'(i));
        for (int i = 0; i < 8; i++) begin
            e = exp_pc_q.pop_front();
            n_cmp++; if (pc !== e) begin n_bad++;
                $display("FAIL pre_reset_run[%0d] got pc=%0d want %0d", i, pc, e); end
            if (i < 7) tick();
        end
        reset = 1'b1;
        req   = 1'b0;
        tick();
        n_cmp++; if ({busy, core_en, core_rst, done, timeout} !== 5'b00100 || pc !== 12'd0 || cnt !== 16'd0) begin n_bad++;
            $display("FAIL midrun_reset got busy/en/rst/done/to=%b pc=%0d cnt=%0d want 00100 0 0",
                     {busy, core_en, core_rst, done, timeout}, pc, cnt); end
        reset = 1'b0;
        tick();
        n_cmp++; if (core_rst !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got rst=%b want 0", core_rst); end
        req = 1'b1;
        tick();
        n_cmp++; if (core_rst !== 1'b1 || busy !== 1'b1) begin n_bad++;
            $display("FAIL reclear got rst=%b busy=%b want 1 1", core_rst, busy); end
        tick();
        n_cmp++; if (core_en !== 1'b1 || core_rst !== 1'b0 || pc !== 12'd0) begin n_bad++;
            $display("FAIL rerun got en=%b rst=%b pc=%0d want 1 0 0", core_en, core_rst, pc); end
        req = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit expired before summary");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; req = 1'b0; req_wd = 1'b0; req_wr = 1'b0;
        halt = 1'b0; branch = 1'b0; stall = 1'b0; target = 12'h000;
        tick(); tick();
        test_reset();
        test_straight_line();
        test_branch_halt();
        test_stall();
        test_watchdog();
        test_no_watchdog_abort();
        test_wrap_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program sequencer for the single-cycle core: it owns the program counter and a run-control state machine that carries the `req`/`done` handshake. Compared with the previous fixed 12-bit PC, it adds:
- a start/finish protocol,
- a core-local reset pulse,
- stall support,
- a cycle counter,
- an optional watchdog timeout.

It sits between the top-level `req`/`done` pins and the instruction ROM, PC LUT, control and ALU branch outputs.

## Interface
- `PC_W`, 12, program counter width in bits.
- `START_ADDR`, 0, PC value loaded at the start of every run.
- `CYC_W`, 16, cycle counter width in bits.
- `MAX_CYCLES`, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  run request; 4-phase handshake with `done`.
- `halt`  in  1  program-done indication from the instruction ROM for the current `prog_ctr`.
- `branch`  in  1  taken branch: ALU branch flag OR control branch flag.
- `target`  in  `PC_W`  branch target from the PC LUT.
- `stall`  in  1  hold the PC this cycle.
- `prog_ctr`  out  `PC_W`  current program counter.
- `core_en`  out  1  high while in RUN; gates register-file and memory writes in the core.
- `core_rst`  out  1  one-cycle clear pulse to the core's architectural state.
- `busy`  out  1  high in CLEAR and RUN.
- `done`  out  1  run finished; registered.
- `timeout`  out  1  run ended by the watchdog; valid while `done` = 1.
- `cycle_count`  out  `CYC_W`  number of RUN cycles in the current or last run; saturates at all-ones.

## Operation
States and transitions:
- IDLE: if `req` = 1, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - drive `core_rst` = 1;
  - load `prog_ctr` = `START_ADDR`;
  - clear `cycle_count`, `done` and `timeout`;
  - go to RUN.
- RUN: `core_en` = 1. `cycle_count` increments every RUN cycle, saturating at 2^`CYC_W` − 1. Per cycle, in priority order:
  1. `req` = 0: abort; go to IDLE; `prog_ctr` and `cycle_count` freeze; `done` stays 0.
  2. `stall` = 1: `prog_ctr` holds; `halt` and `branch` are ignored.
  3. `halt` = 1: go to DONE; `done` = 1, `timeout` = 0; `prog_ctr` holds. `halt` beats `branch` in the same cycle.
  4. watchdog (`MAX_CYCLES` ≠ 0 and this is RUN cycle number `MAX_CYCLES`): go to DONE; `done` = 1, `timeout` = 1; `prog_ctr` holds.
  5. `branch` = 1: `prog_ctr` ← `target`.
  6. otherwise: `prog_ctr` ← `prog_ctr` + 1, modulo 2^`PC_W` (all-ones wraps to 0).
- DONE:
  - `done` stays 1 while `req` = 1;
  - when `req` = 0, go to IDLE and clear `done` (`timeout` and `cycle_count` are kept for readout);
  - `req` never restarts a run directly from DONE.
- IDLE with `req` already high after an abort is impossible, because an abort requires `req` = 0.

Reset values: state IDLE, `prog_ctr` = `START_ADDR`, `done` = 0, `timeout` = 0, `cycle_count` = 0, `busy` = 0, `core_en` = 0, `core_rst` = 1. `core_rst` is driven high while `reset` is asserted, combined with the CLEAR pulse.

Reset in any state, including mid-RUN, takes effect at the next edge and overrides every other input.

## Timing
- `core_en`, `busy` and `core_rst` are decoded combinationally from the state register (plus `reset`). All other outputs are registered.
- `req` sampled high at edge E0 puts the block in CLEAR. RUN starts at E1 with `prog_ctr` = `START_ADDR`, so the first instruction executes in the cycle after E1.
- Latency from `req` to `done`:
  - `done` is high after the edge that retires the halting RUN cycle;
  - if `halt` is seen in the k-th RUN cycle, `done` rises at edge E1+k and `cycle_count` = k;
  - minimum latency: `done` 3 edges after `req` rises (k = 1).
- Branch: `target` is loaded at the end of the cycle in which `branch` = 1 (same-cycle LUT lookup, registered PC).
- Handshake: `req` must stay high until `done` = 1. `done` falls one edge after `req` is seen low.

## Test plan
- Straight-line: `START_ADDR` = 0, `req` = 1, `halt` asserted when `prog_ctr` = 5. Required: sequence 0,1,2,3,4,5; `done` = 1, `cycle_count` = 6, `timeout` = 0; drop `req` → `done` = 0 on the next edge.
- Branch and halt priority:
  - `branch` = 1 with `target` = 0x20 at `prog_ctr` = 2 → next `prog_ctr` = 0x20;
  - `branch` and `halt` both = 1 at 0x20 → `done` = 1, `prog_ctr` stays 0x20.
- Stall: `stall` = 1 for 3 cycles at `prog_ctr` = 3, with `halt` = 1 during the stall. Required: `prog_ctr` holds at 3, `done` stays 0, `cycle_count` still increments by 3.
- Watchdog: `MAX_CYCLES` = 10, `halt` never asserted. Required: `done` = 1 and `timeout` = 1 after the 10th RUN cycle, `cycle_count` = 10. With `MAX_CYCLES` = 0, no termination after 1000 cycles.
- Wrap and abort:
  - `PC_W` = 4, `START_ADDR` = 14 → `prog_ctr` sequence 14,15,0,1;
  - drop `req` mid-RUN → IDLE next edge, `done` never rises.
- Reset mid-run: assert `reset` at `prog_ctr` = 7 in RUN. Required next edge: IDLE, `prog_ctr` = `START_ADDR`, `cycle_count` = 0, all flags 0. A new `req` then produces the CLEAR pulse (`core_rst` = 1) again.
